serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Parametrised multi-cycle subtractor computing a − b − borrow_in over WIDTH bits, DIGIT bits per clock, with a start/busy/done handshake. It extends the single-bit subtractor to word widths and carries the borrow chain across cycles. Status flags (borrow, signed overflow, zero) are produced alongside the result. It is the arithmetic building block for the team's sequential datapath examples.

## Interface
- WIDTH, 8, operand and result width in bits; ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH; STEPS = WIDTH/DIGIT.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- a  in  WIDTH  minuend, captured on the accepted start.
- b  in  WIDTH  subtrahend, captured on the accepted start.
- borrow_in  in  1  initial borrow, captured on the accepted start.
- signed_mode  in  1  1 = two's-complement overflow detection; captured on the accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result becomes valid.
- diff  out  WIDTH  result (a − b − borrow_in) mod 2^WIDTH.
- borrow_out  out  1  final borrow; 1 iff unsigned a < b + borrow_in.
- overflow  out  1  signed overflow; forced 0 when the captured signed_mode = 0.
- zero  out  1  1 iff diff == 0.

## Operation
- FSM states:
  - IDLE: start = 1 captures a, b, borrow_in and signed_mode, clears the step counter, and enters RUN. start = 0 stays in IDLE.
  - RUN: each edge subtracts the lowest DIGIT-bit slice of the operand shift registers using the running borrow. The slice result shifts into the result register from the MSB end, and the borrow register is updated.
  - RUN → IDLE: on the edge completing step STEPS−1.
- On that final edge, the following are all registered together:
  - diff and borrow_out.
  - zero.
  - overflow = signed_mode & (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]).
  - done = 1 for exactly one cycle.
- diff, borrow_out, overflow and zero hold until the next operation completes.
- They are not disturbed during a subsequent RUN; working state lives in separate internal shift registers.
- start while busy is ignored; the captured operands are unaffected.
- start while done = 1 is accepted, giving back-to-back operation with no idle gap.
- Input changes after capture have no effect.

## Timing
- Reset values: busy 0, done 0, diff 0, borrow_out 0, overflow 0, zero 0; FSM in IDLE.
- Reset mid-operation: the operation is aborted and outputs return to reset values immediately (asynchronous). No done is issued.
- Edge k samples start = 1 in IDLE. busy = 1 from after edge k.
- Edge k+STEPS completes the operation: busy = 0 and done = 1 after it; done = 0 after edge k+STEPS+1 unless a new completion occurs.
- Latency from start edge to valid result: STEPS edges.
- Throughput: one result per STEPS cycles.
- Widths:
  - Slice arithmetic is DIGIT+1 bits wide; the extra MSB is the slice borrow.
  - The step counter is clog2(STEPS) bits, minimum 1.
  - The counter is compared to STEPS−1; it never wraps in use.
- DIGIT = WIDTH (STEPS = 1) is legal and gives single-cycle latency.

## Structure
- Shared package subtractor_pkg holds:
  - the state encoding (IDLE, RUN);
  - a clog2-based counter-width function;
  - a parameter-legality check, giving an elaboration error if WIDTH % DIGIT ≠ 0.
- One sub-module, subtractor_slice: combinational DIGIT-bit full subtractor with ports x, y, bin, d, bout.
  - Instantiated once per top-level instance.
  - Separately testable against the existing 1-bit subtractor truth table when DIGIT = 1.

## Test plan
- WIDTH=8, DIGIT=1, a=0x05, b=0x03, borrow_in=0 → diff=0x02, borrow_out=0, zero=0, overflow=0; done pulses exactly 8 edges after the start edge, busy high for those 8 cycles.
- a=0x03, b=0x05, borrow_in=0 → diff=0xFE, borrow_out=1. With signed_mode=1 → overflow=0.
- signed_mode=1, a=0x80, b=0x01 → diff=0x7F, overflow=1, borrow_out=0. Same operands with signed_mode=0 → overflow=0.
- a=0x10, b=0x0F, borrow_in=1 → diff=0x00, zero=1, borrow_out=0.
- Control sequencing:
  - start re-asserted with different operands during RUN → ignored; the first result is unchanged.
  - start asserted in the done cycle → second result completes 8 edges later.
  - rst pulsed at step 4 → all outputs 0, no done; the next operation completes correctly.
- WIDTH=16, DIGIT=4, a=0x1234, b=0x4321 → diff=0xCF13, borrow_out=1, done 4 edges after start.
- WIDTH=16, DIGIT=16 → done 1 edge after start.

Source files
------------

// File: rtl/subtractor_pkg.sv
// subtractor_pkg: shared FSM encoding, counter sizing and parameter checks for serial_subtractor
//   state_t     : IDLE / RUN controller states
//   cnt_width   : step-counter width, clog2(steps) with a minimum of 1
//   params_ok   : legality of a WIDTH/DIGIT pair
package subtractor_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   function automatic int cnt_width(input int steps);
      return (steps <= 1) ? 1 : $clog2(steps);
   endfunction

   function automatic bit params_ok(input int width, input int digit);
      return width >= 2 && digit >= 1 && digit <= width && width % digit == 0;
   endfunction

endpackage

// File: rtl/subtractor_slice.sv
// subtractor_slice: combinational DIGIT-bit full subtractor, d = x - y - bin
//   x, y : DIGIT-bit minuend / subtrahend slices
//   bin  : incoming borrow
//   d    : DIGIT-bit difference slice
//   bout : outgoing borrow
module subtractor_slice #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             bin,
   output logic [DIGIT-1:0] d,
   output logic             bout
);

   // One extra bit on top: it goes high exactly when the slice result is negative.
   logic [DIGIT:0] r;

   always_comb r = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};

   assign d    = r[DIGIT-1:0];
   assign bout = r[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - borrow_in, DIGIT bits per clock, start/busy/done handshake
//   clk, rst               : clock, asynchronous active-high reset
//   start                  : request, accepted only when idle
//   a, b, borrow_in        : operands, captured on the accepted start
//   signed_mode            : enables two's-complement overflow flag, captured on start
//   busy, done             : operation in progress / one-cycle completion pulse
//   diff, borrow_out       : result and final borrow, held until the next completion
//   overflow, zero         : signed overflow and diff == 0 flags, held likewise
module serial_subtractor
   import subtractor_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             zero
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = cnt_width(STEPS);

   if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr, b_sr, r_sr, nxt_r;
   logic             bor, a_msb, b_msb, smode;
   logic [DIGIT-1:0] sd;
   logic             sb;

   subtractor_slice #(.DIGIT(DIGIT)) u_slice (
      .x   (a_sr[DIGIT-1:0]),
      .y   (b_sr[DIGIT-1:0]),
      .bin (bor),
      .d   (sd),
      .bout(sb)
   );

   // New slice enters at the MSB end; after STEPS shifts the word is in order.
   assign nxt_r = WIDTH'({sd, r_sr} >> DIGIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         a_sr       <= '0;
         b_sr       <= '0;
         r_sr       <= '0;
         bor        <= 1'b0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         smode      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
         zero       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               a_sr  <= a;
               b_sr  <= b;
               bor   <= borrow_in;
               a_msb <= a[WIDTH-1];
               b_msb <= b[WIDTH-1];
               smode <= signed_mode;
               cnt   <= '0;
               busy  <= 1'b1;
               state <= RUN;
            end
         end else begin
            a_sr <= a_sr >> DIGIT;
            b_sr <= b_sr >> DIGIT;
            r_sr <= nxt_r;
            bor  <= sb;
            if (cnt == CW'(STEPS - 1)) begin
               diff       <= nxt_r;
               borrow_out <= sb;
               zero       <= nxt_r == '0;
               overflow   <= smode & (a_msb ^ b_msb) & (nxt_r[WIDTH-1] ^ a_msb);
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: self-checking bench, per-cycle model compare plus directed literal vectors
module tb_serial_subtractor;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int cyc = 0, ks = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // 8-bit, 1 bit per cycle instance
   logic       start8 = 0, bi8 = 0, sm8 = 0;
   logic [7:0] a8 = 0, b8 = 0;
   logic       busy8, done8, bo8, ov8, z8;
   logic [7:0] diff8;

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bi8),
      .signed_mode(sm8), .busy(busy8), .done(done8), .diff(diff8),
      .borrow_out(bo8), .overflow(ov8), .zero(z8)
   );

   // 16-bit instances: 4 bits per cycle and whole word per cycle
   logic        s4 = 0, s16 = 0, bi16 = 0, sm16 = 0;
   logic [15:0] a16 = 0, b16 = 0;
   logic        busy4, done4, bo4, ov4, z4, busyw, donew, bow, ovw, zw;
   logic [15:0] diff4, diffw;

   serial_subtractor #(.WIDTH(16), .DIGIT(4)) u16d4 (
      .clk(clk), .rst(rst), .start(s4), .a(a16), .b(b16), .borrow_in(bi16),
      .signed_mode(sm16), .busy(busy4), .done(done4), .diff(diff4),
      .borrow_out(bo4), .overflow(ov4), .zero(z4)
   );

   serial_subtractor #(.WIDTH(16), .DIGIT(16)) u16d16 (
      .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16), .borrow_in(bi16),
      .signed_mode(sm16), .busy(busyw), .done(donew), .diff(diffw),
      .borrow_out(bow), .overflow(ovw), .zero(zw)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   // Model of the 8-bit instance: an operation accepted at an edge yields its
   // arithmetic result 8 edges later; results hold until the next completion.
   logic       m_busy = 0, m_done = 0, m_bo = 0, m_ov = 0, m_z = 0, m_bi = 0, m_sm = 0;
   logic [7:0] m_diff = 0, m_a = 0, m_b = 0;
   int         m_left = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_diff = 0; m_bo = 0; m_ov = 0; m_z = 0; m_left = 0;
      end else begin
         m_done = 0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_diff = 8'(int'(m_a) - int'(m_b) - int'(m_bi));
               m_bo   = int'(m_a) < int'(m_b) + int'(m_bi);
               m_z    = m_diff == 0;
               m_ov   = m_sm && (m_a[7] != m_b[7]) && (m_diff[7] != m_a[7]);
               m_done = 1;
               m_busy = 0;
            end
         end else if (start8) begin
            m_a = a8; m_b = b8; m_bi = bi8; m_sm = sm8;
            m_busy = 1; m_left = 8;
         end
      end
   end

   always @(negedge clk) begin
      check("busy", busy8, m_busy);
      check("done", done8, m_done);
      check("diff", diff8, m_diff);
      check("borrow_out", bo8, m_bo);
      check("overflow", ov8, m_ov);
      check("zero", z8, m_z);
   end

   task automatic launch8(input logic [7:0] ia, input logic [7:0] ib, input logic ibi, input logic ism);
      a8 = ia; b8 = ib; bi8 = ibi; sm8 = ism; start8 = 1;
      @(posedge clk); #1;
      ks = cyc; start8 = 0;
   endtask

   task automatic wait8(input string name, input logic [7:0] ed, input logic ebo,
                        input logic eov, input logic ez);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = done8;
      end
      check({name, "_done_seen"}, 32'(seen), 1);
      check({name, "_latency"}, cyc - ks, 8);
      check({name, "_diff"}, diff8, ed);
      check({name, "_borrow"}, bo8, ebo);
      check({name, "_ovf"}, ov8, eov);
      check({name, "_zero"}, z8, ez);
   endtask

   task automatic run8(input string name, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ibi, input logic ism, input logic [7:0] ed,
                       input logic ebo, input logic eov, input logic ez);
      @(negedge clk);
      launch8(ia, ib, ibi, ism);
      wait8(name, ed, ebo, eov, ez);
   endtask

   task automatic run16(input string name, input bit wide, input logic [15:0] ia,
                        input logic [15:0] ib, input logic ibi, input logic [15:0] ed,
                        input logic ebo, input int elat);
      bit seen = 0;
      @(negedge clk);
      a16 = ia; b16 = ib; bi16 = ibi; sm16 = 0;
      if (wide) s16 = 1; else s4 = 1;
      @(posedge clk); #1;
      ks = cyc; s4 = 0; s16 = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = wide ? donew : done4;
      end
      check({name, "_done_seen"}, 32'(seen), 1);
      check({name, "_latency"}, cyc - ks, elat);
      check({name, "_diff"}, wide ? diffw : diff4, ed);
      check({name, "_borrow"}, wide ? bow : bo4, ebo);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", busy8, 0);
      check("rst_diff", diff8, 0);
      rst = 0;

      run8("sub_05_03", 8'h05, 8'h03, 0, 0, 8'h02, 0, 0, 0);
      run8("sub_03_05", 8'h03, 8'h05, 0, 1, 8'hFE, 1, 0, 0);
      run8("ovf_80_01", 8'h80, 8'h01, 0, 1, 8'h7F, 0, 1, 0);
      run8("nov_80_01", 8'h80, 8'h01, 0, 0, 8'h7F, 0, 0, 0);
      run8("zero_10_0f", 8'h10, 8'h0F, 1, 0, 8'h00, 0, 0, 1);
      run8("sub_00_00_b", 8'h00, 8'h00, 1, 0, 8'hFF, 1, 0, 0);
      run8("ovf_7f_ff", 8'h7F, 8'hFF, 0, 1, 8'h80, 1, 1, 0);

      // start during RUN with other operands is ignored
      @(negedge clk);
      launch8(8'h05, 8'h03, 0, 0);
      repeat (2) @(negedge clk);
      a8 = 8'hAA; b8 = 8'h11; bi8 = 1; sm8 = 1; start8 = 1;
      repeat (3) @(negedge clk);
      start8 = 0;
      wait8("ignore_busy", 8'h02, 0, 0, 0);

      // start in the done cycle: back-to-back
      launch8(8'h20, 8'h21, 0, 1);
      wait8("b2b", 8'hFF, 1, 0, 0);

      // reset mid-operation, then a clean operation
      run8("pre_rst", 8'h80, 8'h01, 0, 1, 8'h7F, 0, 1, 0);
      @(negedge clk);
      launch8(8'h44, 8'h11, 0, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1;
      #1;
      check("arst_busy", busy8, 0);
      check("arst_diff", diff8, 0);
      check("arst_ovf", ov8, 0);
      @(negedge clk);
      rst = 0;
      begin
         int dones = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dones += int'(done8);
         end
         check("arst_no_done", dones, 0);
      end
      run8("post_rst", 8'h44, 8'h11, 0, 0, 8'h33, 0, 0, 0);

      run16("d4_1234_4321", 0, 16'h1234, 16'h4321, 0, 16'hCF13, 1, 4);
      run16("d16_1234_4321", 1, 16'h1234, 16'h4321, 0, 16'hCF13, 1, 1);
      run16("d16_ffff_0001", 1, 16'hFFFF, 16'h0001, 1, 16'hFFFD, 0, 1);
      run16("d4_0000_0000_b", 0, 16'h0000, 16'h0000, 1, 16'hFFFF, 1, 4);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
